data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory controller sitting directly downstream of the `mips` core's memory stage. It owns a word-organised synchronous RAM. It accepts one load/store per request, inserts a programmable number of wait states, and returns `read_data_M` together with a single-cycle `data_mem_ack_M` that releases the core's M-stage stall. Stores support per-byte lane enables for `sb`/`sh`/`sw`.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width; RAM holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2, wait states inserted before acknowledge (0..15).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_M`  in  1  access request; held high by the core until acknowledged.
- `mem_write_M`  in  1  1 = store, 0 = load; sampled with `req_M`.
- `alu_out_M`  in  32  byte address.
- `write_data_M`  in  32  store data, already lane-replicated by the core.
- `byte_en_M`  in  4  store lane enables; lane i covers bits [8i+7:8i].
- `read_data_M`  out  32  full word read from RAM.
- `data_mem_ack_M`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while an access is in flight (states WAIT and ACK).
- `addr_err`  out  1  misalignment flag, pulses with ack (see Configuration).

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE with `req_M`=1 at an edge:
  - latch word index `alu_out_M[ADDR_W+1:2]`, the low two bits, `mem_write_M`, `write_data_M` and `byte_en_M`;
  - load the counter with WAIT_CYCLES;
  - go to WAIT, or straight to ACK if WAIT_CYCLES=0.
- WAIT: the counter decrements each edge. The edge at which the counter equals 1 performs the access and moves to ACK.
- Access at the WAIT→ACK or IDLE→ACK edge:
  - store: writes the enabled lanes only; disabled lanes keep their old value. `read_data_M` is loaded with the post-write word.
  - load: `read_data_M` is loaded with the RAM word.
- ACK: `data_mem_ack_M`=1 for exactly this one cycle. `req_M` is ignored here because the core is still presenting the completing request. The next edge always goes to IDLE.
- Back-to-back accesses therefore have one IDLE cycle between them.
- `read_data_M` holds its value until the next access completes.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
- Store with `byte_en_M`=0000: no lanes change, still acknowledged normally.
- Input changes after the sampling edge have no effect on the access in flight.

## Timing
- Reset (asynchronous, `reset`=0):
  - FSM → IDLE, counter = 0;
  - `data_mem_ack_M`=0, `busy`=0, `addr_err`=0, `read_data_M`=0;
  - RAM contents are not cleared.
- Reset asserted mid-access: the access is abandoned, no RAM write occurs, and no ack is issued.
- Latency: the ack is visible in the cycle after edge WAIT_CYCLES+1, counted from the request-sampling edge as edge 1.
  - WAIT_CYCLES=0: ack in the cycle right after sampling.
  - WAIT_CYCLES=2: the ack follows the third edge.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- `busy` rises on the sampling edge and falls on the ACK→IDLE edge.

## Configuration
- Macro `DMEM_ALIGN_CHECK_EN`.
- Defined: at sampling, an access is flagged misaligned if either:
  - `byte_en_M`=1111 and addr[1:0]≠00, or
  - `byte_en_M` is 0011/1100 and addr[0]=1.
  
  For a misaligned access:
  - no RAM write occurs;
  - `read_data_M` is left unchanged;
  - `addr_err`=1 during the ACK cycle only;
  - timing is unchanged.
- Not defined: the low address bits are ignored, every access proceeds, and `addr_err` is tied to 0.

## Test plan
- Reset, WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 with byte_en=1111, then load 0x10 → `read_data_M`=0xDEADBEEF; each ack arrives after the third edge; one IDLE cycle separates the two accesses.
- Byte store: preload 0x11223344 at 0x20, store 0x000000AA with byte_en=0001 → a subsequent load returns 0x112233AA.
- WAIT_CYCLES=0: a load with `req_M` held continuously → acks in alternating cycles (ack, idle, ack, ...), with `busy` tracking each access.
- Wrap-around, ADDR_W=10: store 0x5 to 0x1000 → a load of 0x0000 returns 0x5.
- Reset at the second WAIT cycle of a store to 0x30 → no ack; a later load of 0x30 returns the old value.
- `DMEM_ALIGN_CHECK_EN` defined: word store to 0x42 → `addr_err`=1 with ack and the RAM word at 0x40 unchanged. Without the macro: `addr_err` stays 0 and the store lands at 0x40.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word RAM behind the M stage with programmable wait states and byte-lane stores.
// Optional misalignment detection is built when DMEM_ALIGN_CHECK_EN is defined.
module data_mem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_M,
  input  logic        mem_write_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] write_data_M,
  input  logic [3:0]  byte_en_M,
  output logic [31:0] read_data_M,
  output logic        data_mem_ack_M,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                mis_q, mis_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem [2**ADDR_W];

  logic                sample, acc_fire, mem_we, mis_now;
  logic [ADDR_W-1:0]   acc_idx;
  logic                acc_wr, acc_mis;
  logic [31:0]         acc_wdata, old_word, merged;
  logic [3:0]          acc_be;

  // Upper address bits wrap away; the low two only matter to the alignment check.
  logic unused_addr;
  assign unused_addr = ^{alu_out_M[31:ADDR_W+2], alu_out_M[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_M) state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      S_WAIT:  if (cnt_q <= 4'd1) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_mem_ack_M = (state_q == S_ACK);
    busy           = (state_q != S_IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
    addr_err       = (state_q == S_ACK) && mis_q;
`else
    addr_err       = 1'b0;
`endif
  end

  assign read_data_M = rdata_q;

  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    mis_now = ((byte_en_M == 4'b1111) && (alu_out_M[1:0] != 2'b00)) ||
              (((byte_en_M == 4'b0011) || (byte_en_M == 4'b1100)) && alu_out_M[0]);
`else
    mis_now = 1'b0;
`endif
  end

  // With zero wait states the access happens on the sampling edge, so it
  // must use the live inputs rather than the latched copies.
  always_comb begin
    sample    = (state_q == S_IDLE) && req_M;
    acc_fire  = (sample && (WAIT_CYCLES == 0)) || ((state_q == S_WAIT) && (cnt_q <= 4'd1));
    acc_idx   = sample ? alu_out_M[ADDR_W+1:2] : idx_q;
    acc_wr    = sample ? mem_write_M           : wr_q;
    acc_wdata = sample ? write_data_M          : wdata_q;
    acc_be    = sample ? byte_en_M             : be_q;
    acc_mis   = sample ? mis_now               : mis_q;
    old_word  = mem[acc_idx];
    merged    = old_word;
    for (int i = 0; i < 4; i++)
      if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
    // Gate on reset so an edge seen while reset is low can never write.
    mem_we    = acc_fire && acc_wr && !acc_mis && reset;
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    if (sample) begin
      cnt_d   = WAIT_INIT;
      idx_d   = alu_out_M[ADDR_W+1:2];
      wr_d    = mem_write_M;
      wdata_d = write_data_M;
      be_d    = byte_en_M;
      mis_d   = mis_now;
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (acc_fire && !acc_mis)
      rdata_d = acc_wr ? merged : old_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset; lane-wise writes map onto byte-enabled block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we && acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a word-array reference model; WAIT_CYCLES=2 main DUT plus a WAIT_CYCLES=0 DUT.
module tb_data_mem_ctrl;

  localparam int WC = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rd;
  logic        ack, busy, aerr;

  logic        req0 = 1'b0;
  logic [31:0] rd0;
  logic        ack0, busy0, aerr0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_m [1024];
  logic [31:0] rd_m = '0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(rst_n), .req_M(req), .mem_write_M(wr), .alu_out_M(addr),
    .write_data_M(wdata), .byte_en_M(be), .read_data_M(rd), .data_mem_ack_M(ack),
    .busy(busy), .addr_err(aerr)
  );

  data_mem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .req_M(req0), .mem_write_M(1'b0), .alu_out_M(32'h0),
    .write_data_M(32'h0), .byte_en_M(4'hF), .read_data_M(rd0), .data_mem_ack_M(ack0),
    .busy(busy0), .addr_err(aerr0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete request/ack handshake, checked against the word-array model.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit          mis;
    bit          got;
    int          lat;
    logic [9:0]  ix;
    logic [31:0] r;
    mis = ALIGN && ((b == 4'hF && a[1:0] != 2'b00) || ((b == 4'h3 || b == 4'hC) && a[0]));
    req = 1'b1; wr = w; addr = a; wdata = d; be = b;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ack) got = 1'b1;
      else chk("busy_wait", {31'b0, busy}, 32'd1);
      if (lat == 1) begin
        r = $urandom; addr = r; wdata = $urandom; be = 4'($urandom); wr = ~w;
      end
    end
    chk("ack_seen", {31'b0, got}, 32'd1);
    chk("latency", lat, WC + 1);
    ix = a[11:2];
    if (!mis) begin
      if (w)
        for (int i = 0; i < 4; i++)
          if (b[i]) mem_m[ix][8*i +: 8] = d[8*i +: 8];
      rd_m = mem_m[ix];
    end
    chk("rdata", rd, rd_m);
    chk("addr_err", {31'b0, aerr}, {31'b0, mis});
    req = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", {31'b0, ack}, 32'd0);
    chk("busy_drop", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  b;
    #3;
    chk("rst_ack",  {31'b0, ack},  32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_aerr", {31'b0, aerr}, 32'd0);
    chk("rst_rdata", rd, 32'd0);
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states with request held: ack every other cycle.
    req0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("wc0_ack",  {31'b0, ack0},  {31'b0, (k % 2 == 0)});
      chk("wc0_busy", {31'b0, busy0}, {31'b0, (k % 2 == 0)});
      chk("wc0_aerr", {31'b0, aerr0}, 32'd0);
    end
    req0 = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) access(1'b1, i * 4, $urandom, 4'hF);

    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    chk("deadbeef", rd, 32'hDEADBEEF);

    access(1'b1, 32'h20, 32'h11223344, 4'hF);
    access(1'b1, 32'h20, 32'h000000AA, 4'h1);
    access(1'b0, 32'h20, 32'h0, 4'h0);
    chk("byte_store", rd, 32'h112233AA);

    access(1'b1, 32'h1000, 32'h5, 4'hF);
    access(1'b0, 32'h0000, 32'h0, 4'h0);
    chk("wrap", rd, 32'h5);

    access(1'b1, 32'h20, 32'hCAFE0000, 4'h0);
    access(1'b0, 32'h20, 32'h0, 4'h0);

    access(1'b1, 32'h40, 32'h01020304, 4'hF);
    access(1'b1, 32'h42, 32'hA5A5A5A5, 4'hF);
    access(1'b0, 32'h40, 32'h0, 4'h0);
    chk("align_word", rd, ALIGN ? 32'h01020304 : 32'hA5A5A5A5);

    // Reset during the second WAIT cycle of a store abandons it.
    req = 1'b1; wr = 1'b1; addr = 32'h30; wdata = 32'hBAD0BAD0; be = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rd_m = '0;
    chk("midrst_busy",  {31'b0, busy}, 32'd0);
    chk("midrst_rdata", rd, 32'd0);
    @(posedge clk); #1;
    chk("midrst_ack", {31'b0, ack}, 32'd0);
    req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ack2", {31'b0, ack}, 32'd0);
    access(1'b0, 32'h30, 32'h0, 4'h0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      a[11:8] = 4'h0;
      case ($urandom_range(0, 3))
        0: b = 4'hF;
        1: b = $urandom_range(0, 1) ? 4'h3 : 4'hC;
        2: b = 4'($urandom);
        default: b = 4'h0;
      endcase
      access(1'($urandom_range(0, 1)), a, $urandom, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
